// File: rtl/vacc_bram_if.sv
// Sample/control bundle between a vector-accumulator user (master) and vacc_bram (slave).
interface vacc_bram_if #(
  parameter int WIDTH_IN  = 18,
  parameter int WIDTH_ACC = 32
);
  logic                        ce;
  logic                        sync_in;
  logic [31:0]                 acc_len;
  logic signed [WIDTH_IN-1:0]  din;
  logic signed [WIDTH_ACC-1:0] dout;
  logic                        valid_out;
  logic                        sync_out;

  modport master (
    output ce, sync_in, acc_len, din,
    input  dout, valid_out, sync_out
  );

  modport slave (
    input  ce, sync_in, acc_len, din,
    output dout, valid_out, sync_out
  );
endinterface

// File: rtl/vacc_bram.sv
// Vector accumulator with a BRAM delay-line feedback; dout follows din by 1 cycle during a dump.
// No backpressure: one sample is consumed every clk, ce is ignored.
module bram_delay_behave #(
  parameter int WIDTH   = 32,
  parameter int DELAY   = 7,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  // Ring depth plus read pipeline adds up to DELAY cycles in total.
  localparam int DEPTH = DELAY - LATENCY;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] rd_q;

  assign addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  always_ff @(posedge clk) begin
    rd_q         <= mem[addr_q];
    mem[addr_q]  <= din;
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [WIDTH-1:0] pipe_q;
      always_ff @(posedge clk) pipe_q <= rd_q;
      assign dout = pipe_q;
    end else begin : g_nopipe
      assign dout = rd_q;
    end
  endgenerate
endmodule

module vacc_bram #(
  parameter int WIDTH_IN  = 18,
  parameter int WIDTH_ACC = 32,
  parameter int VEC_LEN   = 1024,
  parameter int LATENCY   = 2
) (
  input logic        clk,
  input logic        rst,
  vacc_bram_if.slave bus
);
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [31:0]                 vcnt_q, vcnt_d;
  logic [31:0]                 n_q, n_d;
  logic signed [WIDTH_ACC-1:0] dout_q, dout_d;
  logic                        valid_q, valid_d;
  logic                        sync_q, sync_d;
  logic signed [WIDTH_ACC-1:0] din_ext, fb, sum, sum_q;

  wire unused_ce = bus.ce;

  assign din_ext = WIDTH_ACC'(bus.din);
  // First vector of an integration ignores the feedback, so stale RAM data never leaks in.
  assign sum     = (vcnt_q == '0) ? din_ext : fb + din_ext;

  always_ff @(posedge clk) sum_q <= sum;

  bram_delay_behave #(
    .WIDTH  (WIDTH_ACC),
    .DELAY  (VEC_LEN - 1),
    .LATENCY(LATENCY)
  ) u_fb_delay (
    .clk (clk),
    .rst (rst),
    .din (sum_q),
    .dout(fb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vcnt_d  = vcnt_q;
    n_d     = n_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    // A restart wins over everything, including an index wrap or a dump in progress.
    if (bus.sync_in) begin
      state_d = S_ACCUM;
      idx_d   = '0;
      vcnt_d  = '0;
      n_d     = (bus.acc_len == 32'd0) ? 32'd1 : bus.acc_len;
    end else if (state_q == S_ACCUM) begin
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        vcnt_d = (vcnt_q == n_q - 32'd1) ? 32'd0 : vcnt_q + 32'd1;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
      if (vcnt_q == n_q - 32'd1) begin
        valid_d = 1'b1;
        sync_d  = (idx_q == '0);
        dout_d  = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vcnt_q  <= '0;
      n_q     <= 32'd1;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vcnt_q  <= vcnt_d;
      n_q     <= n_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid_out = valid_q;
  assign bus.sync_out  = sync_q;
endmodule

// File: tb/tb_vacc_bram.sv
// Directed bench for vacc_bram: 32-bit/latency-2 instance for timing and restart cases,
// 18-bit/latency-1 instance for modular wrap.
module tb_vacc_bram;
  localparam int VL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vacc_bram_if #(.WIDTH_IN(18), .WIDTH_ACC(32)) b1 ();
  vacc_bram_if #(.WIDTH_IN(18), .WIDTH_ACC(18)) b2 ();

  vacc_bram #(.WIDTH_IN(18), .WIDTH_ACC(32), .VEC_LEN(VL), .LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  vacc_bram #(.WIDTH_IN(18), .WIDTH_ACC(18), .VEC_LEN(VL), .LATENCY(1)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse sync_in now with the given acc_len, then stream ncyc samples and check
  // every output cycle. mode 0: constant din=val; mode 1: din=element index.
  task automatic run_check(input int acc, input int mode, input int val, input int ncyc);
    int n, first, rel, el, exp_v;
    logic vld_e;
    n     = (acc < 1) ? 1 : acc;
    first = 8 * n - 6;
    b1.sync_in = 1'b1;
    b1.acc_len = acc;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      b1.sync_in = 1'b0;
      rel   = k - first;
      vld_e = (k >= first) && ((rel % (VL * n)) < VL);
      check($sformatf("valid acc=%0d k=%0d", acc, k), {31'd0, b1.valid_out}, {31'd0, vld_e});
      check($sformatf("sync acc=%0d k=%0d", acc, k), {31'd0, b1.sync_out},
            {31'd0, vld_e && ((rel % (VL * n)) == 0)});
      if (vld_e) begin
        el    = (k - 2) % VL;
        exp_v = n * ((mode == 1) ? el : val);
        check($sformatf("dout acc=%0d k=%0d", acc, k), b1.dout, exp_v);
      end
      b1.din = (mode == 1) ? 18'((k - 1) % VL) : 18'(val);
    end
  endtask

  initial begin
    b1.ce = 1'b1; b1.sync_in = 1'b0; b1.acc_len = 32'd4; b1.din = 18'd7;
    b2.ce = 1'b1; b2.sync_in = 1'b0; b2.acc_len = 32'd2; b2.din = 18'd7;
    rst = 1'b1;
    repeat (3) tick();
    check("reset valid", {31'd0, b1.valid_out}, 32'd0);
    check("reset sync",  {31'd0, b1.sync_out},  32'd0);
    check("reset dout",  b1.dout, 32'd0);
    rst = 1'b0;

    // Idle: din ignored, no output without sync_in
    for (int k = 0; k < 12; k++) begin
      tick();
      check("idle valid", {31'd0, b1.valid_out}, 32'd0);
    end

    run_check(4, 0, 1, 40);   // constant 1, dump at t0+26..33
    run_check(4, 1, 0, 66);   // ramp, two dumps 32 cycles apart
    run_check(0, 0, -3, 20);  // pass-through, valid continuous
    run_check(1, 1, 0, 12);

    // Restart mid-integration: first call ends at t0+13, second resyncs there
    run_check(4, 0, 1, 13);
    run_check(4, 0, 1, 36);

    // Reset during a dump
    run_check(4, 0, 1, 28);
    check("pre-rst dump active", {31'd0, b1.valid_out}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst valid", {31'd0, b1.valid_out}, 32'd0);
    check("rst dout",  b1.dout, 32'd0);
    check("rst sync",  {31'd0, b1.sync_out}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("post-rst idle valid", {31'd0, b1.valid_out}, 32'd0);
    end
    run_check(4, 0, 2, 34);

    // 18-bit accumulator wrap: 0x1FFFF + 0x1FFFF = 0x3FFFE (-2)
    b2.sync_in = 1'b1;
    b2.acc_len = 32'd2;
    b2.din     = 18'h1FFFF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      b2.sync_in = 1'b0;
      check($sformatf("w18 valid k=%0d", k), {31'd0, b2.valid_out},
            {31'd0, (k >= 10 && k <= 17)});
      if (k >= 10 && k <= 17)
        check($sformatf("w18 dout k=%0d", k), {14'd0, b2.dout}, 32'h0003FFFE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vacc_bram.md
VACC_BRAM -- requirements
Module: vacc_bram

Interface
REQ-001 Parameter WIDTH_IN, default 18, signed input sample width in bits.
REQ-002 Parameter WIDTH_ACC, default 32, signed accumulator and output width in bits; SHALL be >= WIDTH_IN.
REQ-003 Parameter VEC_LEN, default 1024, samples per vector; SHALL be >= 4.
REQ-004 Parameter LATENCY, default 2, read latency of the feedback delay-line RAM (1 or 2).
REQ-005 clk  input  1  rising-edge clock; sole clock domain.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 ce  input  1  clock enable for Simulink compatibility; ignored internally, block advances every clk.
REQ-008 sync_in  input  1  one-cycle pulse; the cycle after it carries element 0 of a vector.
REQ-009 acc_len  input  32  vectors per integration, sampled only on sync_in.
REQ-010 din  input  WIDTH_IN  signed sample, one per clk.
REQ-011 dout  output  WIDTH_ACC  signed accumulated sample.
REQ-012 valid_out  output  1  high while dout carries a completed integration.
REQ-013 sync_out  output  1  one-cycle pulse coincident with element 0 of each dumped vector.

Function
REQ-014 States: IDLE (after reset, waiting for sync_in) and ACCUM; IDLE->ACCUM on sync_in; ACCUM->ACCUM (restart) on sync_in; any state->IDLE on rst.
REQ-015 In IDLE, din SHALL be ignored and valid_out, sync_out SHALL be 0.
REQ-016 Element counter idx counts 0..VEC_LEN-1, cleared so that the cycle after sync_in is idx=0, wraps VEC_LEN-1->0.
REQ-017 Vector counter vcnt counts 0..N-1, N = max(acc_len,1) latched at sync_in; increments on idx wrap, wraps N-1->0.
REQ-018 sum = sign_extend(din) when vcnt==0; otherwise sum = fb + sign_extend(din), fb being the sum for the same idx one vector earlier.
REQ-019 Arithmetic SHALL be two's complement modulo 2^WIDTH_ACC; overflow wraps silently, no saturation.
REQ-020 sum SHALL be registered (1 cycle) and fed to a bram_delay_behave instance with DELAY=VEC_LEN-1, LATENCY=LATENCY, so total feedback loop = VEC_LEN cycles.
REQ-021 Feedback contents after reset or restart are undefined; the vcnt==0 rule SHALL make them irrelevant.
REQ-022 When vcnt==N-1, registered sum SHALL appear on dout one cycle after the corresponding din with valid_out=1, for all VEC_LEN elements.
REQ-023 sync_out SHALL pulse with the idx=0 output of each dump; valid_out deasserts the cycle after idx=VEC_LEN-1 output unless the next dump follows (N=1).
REQ-024 N=1 (acc_len 0 or 1): dout = sign_extend(din) delayed 1 cycle, valid_out continuously high in ACCUM.
REQ-025 sync_in during ACCUM: partial integration SHALL be discarded (no valid output for it); idx, vcnt restart; acc_len relatched; an in-progress dump is truncated.
REQ-026 sync_in coincident with idx wrap: sync_in SHALL take priority.
REQ-027 dout SHALL hold last value when valid_out=0 (no requirement on content).

Reset
REQ-028 On rst: state=IDLE, idx=0, vcnt=0, dout=0, valid_out=0, sync_out=0; applies mid-integration and mid-dump, next output only after a fresh sync_in plus a full integration.
REQ-029 RAM contents SHALL NOT require clearing on reset.

Verification (VEC_LEN=8, WIDTH_IN=18, WIDTH_ACC=32)
REQ-030 acc_len=4, din=1 constant, sync at t0 -> valid_out high cycles t0+26..t0+33, dout=4 each, sync_out at t0+26 only.
REQ-031 acc_len=4, din=idx (0..7) -> dout = 0,4,8,...,28 in order; repeats every 32 cycles.
REQ-032 acc_len=0, din=-3 -> dout=-3 (0xFFFFFFFD) every cycle from t0+2, valid_out continuous, sync_out every 8 cycles.
REQ-033 acc_len=4, second sync_in at t0+13 -> no valid_out before t0+13+26, then dout=4 per element.
REQ-034 WIDTH_ACC=18, acc_len=2, din=0x1FFFF (131071) -> dout=0x3FFFE (-2), wrap confirmed.
REQ-035 rst asserted during dump -> next cycle valid_out=0, dout=0; no output until sync_in plus 26 cycles.
